// File: rtl/sign_ext_pkg.sv
// Shared types and widths for the immediate-extension unit.
// Build option: SIGN_EXT_BRANCH_MODE_EN enables the branch-offset mode.
package sign_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_LUI    = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_e;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/sign_ext_if.sv
// Request/result bundle between the immediate field and the extender.
// Build option: SIGN_EXT_BRANCH_MODE_EN (affects mode 11 only).
interface sign_ext_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  i0;
    logic [1:0]       mode;
    logic             in_valid;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             out_neg;

    modport master (
        output i0, mode, in_valid,
        input  out, out_valid, out_neg
    );

    modport slave (
        input  i0, mode, in_valid,
        output out, out_valid, out_neg
    );
endinterface

// File: rtl/sign_ext_core.sv
// Combinational mode decode and immediate widening.
// Build option: SIGN_EXT_BRANCH_MODE_EN adds the shifted branch offset.
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  i0,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext_word
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] lui;
    ext_mode_e        m;

    assign m    = ext_mode_e'(mode);
    assign sext = {{PAD_W{i0[IN_W-1]}}, i0};
    assign zext = {{PAD_W{1'b0}}, i0};
    // Immediate lands in the top IN_W bits even when PAD_W != IN_W.
    assign lui  = zext << PAD_W;

    // Select the extension for the requested mode; mode 11 falls back to SIGN.
    always_comb begin
        ext_word = sext;
        unique case (1'b1)
            (m == EXT_ZERO): ext_word = zext;
            (m == EXT_LUI):  ext_word = lui;
`ifdef SIGN_EXT_BRANCH_MODE_EN
            (m == EXT_BRANCH): ext_word = sext << 2;
`endif
            default: ext_word = sext;
        endcase
    end
endmodule

// File: rtl/sign_ext.sv
// Registered immediate extender: one-cycle latency with valid flag.
// Build option: SIGN_EXT_BRANCH_MODE_EN enables mode 11 as branch offset.
module sign_ext
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input logic     clk,
    input logic     reset,
    sign_ext_if.slave bus
);
    logic [OUT_W-1:0] ext_word;

    sign_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i0       (bus.i0),
        .mode     (bus.mode),
        .ext_word (ext_word)
    );

    // Capture result on each accepted sample; hold data when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_neg   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out     <= ext_word;
                bus.out_neg <= bus.i0[IN_W-1];
            end
        end
    end
endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: scoreboard of model results
// plus directed literal checks on the documented cases.
module tb_sign_ext;
    typedef struct packed {
        logic        v;
        logic [31:0] o;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [31:0] m_out = '0;
    logic        m_neg = 1'b0;

    sign_ext_if #(.IN_W(16), .OUT_W(32)) bus ();

    sign_ext #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_ext(input logic [1:0] m, input logic [15:0] x);
        logic [31:0] s;
        s = x[15] ? {16'hFFFF, x} : {16'h0000, x};
        case (m)
            2'b01: return {16'h0000, x};
            2'b10: return {x, 16'h0000};
`ifdef SIGN_EXT_BRANCH_MODE_EN
            2'b11: return {s[29:0], 2'b00};
`endif
            default: return s;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [15:0] x);
        exp_t e;
        reset        = r;
        bus.in_valid = v;
        bus.mode     = m;
        bus.i0       = x;
        if (r) begin
            m_out = '0;
            m_neg = 1'b0;
        end else if (v) begin
            m_out = model_ext(m, x);
            m_neg = x[15];
        end
        e.v = v & ~r;
        e.o = m_out;
        e.n = m_neg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_valid", {31'd0, bus.out_valid}, {31'd0, e.v});
            chk("sb_out", bus.out, e.o);
            chk("sb_neg", {31'd0, bus.out_neg}, {31'd0, e.n});
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.i0       = '0;
        @(negedge clk);

        step(1'b1, 1'b1, 2'b00, 16'h8000);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_neg", {31'd0, bus.out_neg}, 32'd0);

        step(1'b0, 1'b1, 2'b00, 16'h8000);
        chk("sign_8000", bus.out, 32'hFFFF8000);
        chk("sign_8000_neg", {31'd0, bus.out_neg}, 32'd1);
        chk("sign_8000_v", {31'd0, bus.out_valid}, 32'd1);
        step(1'b0, 1'b1, 2'b00, 16'h4000);
        chk("sign_4000", bus.out, 32'h00004000);
        chk("sign_4000_neg", {31'd0, bus.out_neg}, 32'd0);
        step(1'b0, 1'b1, 2'b00, 16'h7FFF);
        chk("sign_7fff", bus.out, 32'h00007FFF);
        step(1'b0, 1'b1, 2'b00, 16'h0000);
        chk("sign_0000", bus.out, 32'h00000000);
        step(1'b0, 1'b1, 2'b00, 16'hFFFF);
        chk("sign_ffff", bus.out, 32'hFFFFFFFF);
        step(1'b0, 1'b1, 2'b01, 16'h8000);
        chk("zero_8000", bus.out, 32'h00008000);
        chk("zero_8000_neg", {31'd0, bus.out_neg}, 32'd1);
        step(1'b0, 1'b1, 2'b10, 16'h1234);
        chk("lui_1234", bus.out, 32'h12340000);
        step(1'b0, 1'b1, 2'b11, 16'hFFFF);
`ifdef SIGN_EXT_BRANCH_MODE_EN
        chk("mode3_ffff", bus.out, 32'hFFFFFFFC);
`else
        chk("mode3_ffff", bus.out, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b01, 16'h5555);
`ifdef SIGN_EXT_BRANCH_MODE_EN
            chk("idle_hold", bus.out, 32'hFFFFFFFC);
`else
            chk("idle_hold", bus.out, 32'hFFFFFFFF);
`endif
            chk("idle_v", {31'd0, bus.out_valid}, 32'd0);
        end

        step(1'b1, 1'b1, 2'b00, 16'h8000);
        chk("rst2_out", bus.out, 32'h0);
        chk("rst2_v", {31'd0, bus.out_valid}, 32'd0);
        step(1'b0, 1'b1, 2'b00, 16'h0001);
        chk("post_rst", bus.out, 32'h00000001);
        chk("post_rst_v", {31'd0, bus.out_valid}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
